// File: rtl/step_shaper.sv
// Step/direction shaper: turns raw step edges from the motion engine into
// driver-legal pulses with fixed width, minimum gap and direction setup/hold.
module step_shaper #(
    parameter int MOTORS    = 3,
    parameter int CNT_W     = 8,
    parameter int PULSE_W   = 8,
    parameter int DIR_SETUP = 4,
    parameter int GAP_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MOTORS-1:0] step_in,
    input  logic [MOTORS-1:0] dir_in,
    input  logic              ovr_clr,
    output logic [MOTORS-1:0] step_out,
    output logic [MOTORS-1:0] dir_out,
    output logic [MOTORS-1:0] busy,
    output logic [MOTORS-1:0] overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(GAP_W - 1);

    logic [MOTORS-1:0] s1_q, s2_q, d1_q;

    // Edge detectors come out of reset high so a step line already high is not a new edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '1;
            s2_q <= '1;
            d1_q <= '0;
        end else begin
            s1_q <= step_in;
            s2_q <= s1_q;
            d1_q <= dir_in;
        end
    end

    for (genvar m = 0; m < MOTORS; m++) begin : g_motor
        logic             push, pop, drop;
        logic [1:0]       fill_q, fill_d;
        logic             head_q, head_d, tail_q, tail_d;
        logic             ovr_q, ovr_d;
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             step_q, step_d, dir_q, dir_d;

        // Two-entry direction queue; a pop shifts the tail into the head slot.
        always_comb begin
            push   = s1_q[m] & ~s2_q[m];
            pop    = (state_q == S_IDLE) && (fill_q != 2'd0);
            drop   = push && !pop && (fill_q == 2'd2);
            head_d = head_q;
            tail_d = tail_q;
            fill_d = fill_q;
            case ({push, pop})
                2'b10: begin
                    if (fill_q == 2'd0) begin
                        head_d = d1_q[m];
                        fill_d = 2'd1;
                    end else if (fill_q == 2'd1) begin
                        tail_d = d1_q[m];
                        fill_d = 2'd2;
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    fill_d = fill_q - 2'd1;
                end
                2'b11: begin
                    if (fill_q == 2'd1) begin
                        head_d = d1_q[m];
                    end else begin
                        head_d = tail_q;
                        tail_d = d1_q[m];
                    end
                end
                default: ;
            endcase
            ovr_d = drop | (ovr_q & ~ovr_clr);
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            step_d  = step_q;
            dir_d   = dir_q;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (head_q != dir_q) begin
                            dir_d   = head_q;
                            cnt_d   = SETUP_INIT;
                            state_d = S_SETUP;
                        end else begin
                            step_d  = 1'b1;
                            cnt_d   = PULSE_INIT;
                            state_d = S_PULSE;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        step_d  = 1'b1;
                        cnt_d   = PULSE_INIT;
                        state_d = S_PULSE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        step_d  = 1'b0;
                        cnt_d   = GAP_INIT;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                fill_q  <= 2'd0;
                head_q  <= 1'b0;
                tail_q  <= 1'b0;
                ovr_q   <= 1'b0;
                state_q <= S_IDLE;
                cnt_q   <= '0;
                step_q  <= 1'b0;
                dir_q   <= 1'b0;
            end else begin
                fill_q  <= fill_d;
                head_q  <= head_d;
                tail_q  <= tail_d;
                ovr_q   <= ovr_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                step_q  <= step_d;
                dir_q   <= dir_d;
            end
        end

        assign step_out[m] = step_q;
        assign dir_out[m]  = dir_q;
        assign overrun[m]  = ovr_q;
        assign busy[m]     = (state_q != S_IDLE) || (fill_q != 2'd0);
    end

endmodule

// File: tb/tb_step_shaper.sv
// Directed bench for step_shaper: default-parameter three-motor instance plus
// a minimum-timing single-motor instance.
module tb_step_shaper;

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] stepIn, dirIn, stepOut, dirOut, busyOut, ovrOut;
    logic       ovrClr;
    logic [0:0] fastStepIn, fastDirIn, fastStepOut, fastDirOut, fastBusy, fastOvr;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    step_shaper dut (
        .clk      (clk),
        .reset    (rstN),
        .step_in  (stepIn),
        .dir_in   (dirIn),
        .ovr_clr  (ovrClr),
        .step_out (stepOut),
        .dir_out  (dirOut),
        .busy     (busyOut),
        .overrun  (ovrOut)
    );

    step_shaper #(.MOTORS(1), .PULSE_W(1), .GAP_W(1), .DIR_SETUP(1)) dutFast (
        .clk      (clk),
        .reset    (rstN),
        .step_in  (fastStepIn),
        .dir_in   (fastDirIn),
        .ovr_clr  (ovrClr),
        .step_out (fastStepOut),
        .dir_out  (fastDirOut),
        .busy     (fastBusy),
        .overrun  (fastOvr)
    );

    // Pulse counters and width/period trackers, sampled on the falling clock edge.
    int         cyc = 0;
    int         riseCnt [3] = '{0, 0, 0};
    int         highLen [3] = '{0, 0, 0};
    int         lastWidth [3] = '{0, 0, 0};
    logic [2:0] prevStep = '0;
    int         fastRise = 0, fastHigh = 0, fastMaxW = 0, fastLastRise = 0, fastPeriod = 0;
    logic       fastPrev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (stepOut[i] && !prevStep[i]) riseCnt[i]++;
            if (stepOut[i]) begin
                highLen[i]++;
            end else if (prevStep[i]) begin
                lastWidth[i] = highLen[i];
                highLen[i]   = 0;
            end
        end
        prevStep = stepOut;
        if (fastStepOut[0] && !fastPrev) begin
            if (fastRise > 0) fastPeriod = cyc - fastLastRise;
            fastLastRise = cyc;
            fastRise++;
        end
        if (fastStepOut[0]) begin
            fastHigh++;
        end else begin
            if (fastHigh > fastMaxW) fastMaxW = fastHigh;
            fastHigh = 0;
        end
        fastPrev = fastStepOut[0];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    int snap, snapFast;

    initial begin
        rstN       = 1'b0;
        stepIn     = 3'b100;
        dirIn      = 3'b000;
        ovrClr     = 1'b0;
        fastStepIn = 1'b0;
        fastDirIn  = 1'b0;
        tick(3);
        checkOutput("reset_step", 32'(stepOut), 32'h0);
        checkOutput("reset_dir", 32'(dirOut), 32'h0);
        checkOutput("reset_busy", 32'(busyOut), 32'h0);
        checkOutput("reset_ovr", 32'(ovrOut), 32'h0);

        // Step line held high across release must not produce a pulse.
        rstN = 1'b1;
        tick(20);
        checkOutput("held_high_pulses", 32'(riseCnt[2]), 32'd0);
        checkOutput("held_high_busy", 32'(busyOut[2]), 32'd0);
        stepIn[2] = 1'b0;
        tick(3);

        $display("[TB] single step, motor 0");
        stepIn[0] = 1'b1;
        tick(1);
        tick(1);
        checkOutput("single_k1_step", 32'(stepOut[0]), 32'd0);
        checkOutput("single_k1_busy", 32'(busyOut[0]), 32'd1);
        stepIn[0] = 1'b0;
        tick(1);
        checkOutput("single_k2_step", 32'(stepOut[0]), 32'd1);
        tick(7);
        checkOutput("single_k9_step", 32'(stepOut[0]), 32'd1);
        tick(1);
        checkOutput("single_k10_step", 32'(stepOut[0]), 32'd0);
        checkOutput("single_dir", 32'(dirOut[0]), 32'd0);
        tick(7);
        checkOutput("single_k17_busy", 32'(busyOut[0]), 32'd1);
        tick(1);
        checkOutput("single_k18_busy", 32'(busyOut[0]), 32'd0);
        checkOutput("single_width", 32'(lastWidth[0]), 32'd8);

        $display("[TB] direction change, motor 1");
        snap = riseCnt[1];
        dirIn[1]  = 1'b1;
        stepIn[1] = 1'b1;
        tick(2);
        checkOutput("dirchg_k1_dir", 32'(dirOut[1]), 32'd0);
        stepIn[1] = 1'b0;
        tick(1);
        checkOutput("dirchg_k2_dir", 32'(dirOut[1]), 32'd1);
        checkOutput("dirchg_k2_step", 32'(stepOut[1]), 32'd0);
        tick(3);
        checkOutput("dirchg_k5_step", 32'(stepOut[1]), 32'd0);
        tick(1);
        checkOutput("dirchg_k6_step", 32'(stepOut[1]), 32'd1);
        tick(30);
        checkOutput("dirchg_width", 32'(lastWidth[1]), 32'd8);
        checkOutput("dirchg_pulses", 32'(riseCnt[1] - snap), 32'd1);

        $display("[TB] burst of four edges, motor 0");
        snap = riseCnt[0];
        for (int i = 0; i < 4; i++) begin
            stepIn[0] = 1'b1;
            tick(1);
            stepIn[0] = 1'b0;
            tick(2);
        end
        checkOutput("burst_ovr0", 32'(ovrOut[0]), 32'd1);
        checkOutput("burst_ovr_others", 32'(ovrOut[2:1]), 32'd0);
        checkOutput("burst_busy_others", 32'(busyOut[2:1]), 32'd0);
        tick(60);
        checkOutput("burst_pulses", 32'(riseCnt[0] - snap), 32'd3);
        checkOutput("burst_ovr_sticky", 32'(ovrOut[0]), 32'd1);
        checkOutput("burst_dir", 32'(dirOut[0]), 32'd0);
        ovrClr = 1'b1;
        tick(1);
        ovrClr = 1'b0;
        checkOutput("burst_ovr_cleared", 32'(ovrOut[0]), 32'd0);

        // Fourth edge is pushed at k+19, the same edge the full queue pops its head.
        $display("[TB] push and pop on a full queue, motor 2");
        snap = riseCnt[2];
        stepIn[2] = 1'b1;
        tick(1);
        stepIn[2] = 1'b0;
        tick(2);
        stepIn[2] = 1'b1;
        tick(1);
        stepIn[2] = 1'b0;
        tick(2);
        stepIn[2] = 1'b1;
        tick(1);
        stepIn[2] = 1'b0;
        tick(11);
        stepIn[2] = 1'b1;
        tick(1);
        stepIn[2] = 1'b0;
        tick(1);
        checkOutput("fullpop_ovr", 32'(ovrOut[2]), 32'd0);
        tick(60);
        checkOutput("fullpop_pulses", 32'(riseCnt[2] - snap), 32'd4);
        checkOutput("fullpop_ovr_end", 32'(ovrOut[2]), 32'd0);

        $display("[TB] clear coinciding with new overrun, motor 0");
        snap = riseCnt[0];
        for (int i = 0; i < 4; i++) begin
            stepIn[0] = 1'b1;
            tick(1);
            stepIn[0] = 1'b0;
            if (i == 3) ovrClr = 1'b1;
            tick(1);
            ovrClr = 1'b0;
            tick(1);
        end
        checkOutput("clrset_ovr", 32'(ovrOut[0]), 32'd1);
        tick(60);
        checkOutput("clrset_pulses", 32'(riseCnt[0] - snap), 32'd3);
        ovrClr = 1'b1;
        tick(1);
        ovrClr = 1'b0;

        $display("[TB] reset during pulse, motor 1");
        stepIn[1] = 1'b1;
        tick(1);
        stepIn[1] = 1'b0;
        tick(2);
        stepIn[1] = 1'b1;
        tick(1);
        stepIn[1] = 1'b0;
        tick(1);
        checkOutput("midrst_pre_step", 32'(stepOut[1]), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midrst_step", 32'(stepOut), 32'h0);
        checkOutput("midrst_busy", 32'(busyOut), 32'h0);
        checkOutput("midrst_dir", 32'(dirOut), 32'h0);
        tick(2);
        rstN = 1'b1;
        snap = riseCnt[1];
        tick(40);
        checkOutput("midrst_after_pulses", 32'(riseCnt[1] - snap), 32'd0);
        checkOutput("midrst_after_busy", 32'(busyOut[1]), 32'd0);

        $display("[TB] minimum timing instance");
        snapFast = fastRise;
        for (int i = 0; i < 4; i++) begin
            fastStepIn[0] = 1'b1;
            tick(1);
            fastStepIn[0] = 1'b0;
            tick(2);
        end
        tick(10);
        checkOutput("fast_pulses", 32'(fastRise - snapFast), 32'd4);
        checkOutput("fast_width", 32'(fastMaxW), 32'd1);
        checkOutput("fast_period", 32'(fastPeriod), 32'd3);
        checkOutput("fast_ovr", 32'(fastOvr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
